// File: rtl/hazard_interlock.sv
// Stall/flush interlock for the 5-stage pipeline: detects hazards the
// forwarding network cannot cover (load-use, load or ALU result feeding an
// ID-stage branch compare, mult/div occupancy), freezes PC/IF_ID, injects an
// ID_EX bubble, counts stall cycles and flags a stuck pipeline.
module hazard_interlock #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32,
    parameter int MAX_STALL  = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [4:0]       ID_RS,
    input  logic [4:0]       ID_RT,
    input  logic             ID_UsesRS,
    input  logic             ID_UsesRT,
    input  logic             ID_Branch,
    input  logic             ID_BranchTaken,
    input  logic             ID_UsesHILO,
    input  logic             ID_MDStart,
    input  logic             ID_EX_RegWrite,
    input  logic             ID_EX_MemtoReg,
    input  logic [4:0]       ID_EX_WriteReg,
    input  logic             EX_MDStart,
    input  logic             EX_MEM_RegWrite,
    input  logic             EX_MEM_MemtoReg,
    input  logic [4:0]       EX_MEM_WriteReg,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             MD_Busy,
    output logic [CNT_W-1:0] STALL_COUNT,
    output logic             WDOG_TRIP
);

    localparam logic [3:0] MdLoad    = 4'(MD_LATENCY);
    localparam logic [7:0] WdogLimit = 8'(MAX_STALL);

    logic [3:0] mdCount;
    logic [7:0] wdogCount;
    logic [7:0] wdogNext;
    logic       exMatch;
    logic       memMatch;
    logic       luHazard;
    logic       blHazard;
    logic       baHazard;
    logic       mdHazard;
    logic       stall;

    // A producer matches when it writes a real register that ID actually reads
    function automatic logic regMatch(
        input logic [4:0] writeReg,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       usesRs,
        input logic       usesRt
    );
        return (writeReg != 5'd0) &&
               ((usesRs && (rs == writeReg)) || (usesRt && (rt == writeReg)));
    endfunction

    // Hazard detection and the combined stall decision
    always_comb begin
        exMatch  = regMatch(ID_EX_WriteReg, ID_RS, ID_RT, ID_UsesRS, ID_UsesRT);
        memMatch = regMatch(EX_MEM_WriteReg, ID_RS, ID_RT, ID_UsesRS, ID_UsesRT);
        luHazard = ID_EX_RegWrite && ID_EX_MemtoReg && exMatch;
        blHazard = ID_Branch && EX_MEM_RegWrite && EX_MEM_MemtoReg && memMatch;
        baHazard = ID_Branch && ID_EX_RegWrite && !ID_EX_MemtoReg && exMatch;
        mdHazard = MD_Busy && (ID_UsesHILO || ID_MDStart);
        stall    = luHazard || blHazard || baHazard || mdHazard;
    end

    // Pipeline control outputs; a stalled branch is not resolved so it never flushes
    always_comb begin
        PC_Write     = !stall;
        IF_ID_Write  = !stall;
        ID_EX_Bubble = stall;
        IF_ID_Flush  = ID_BranchTaken && !stall;
        MD_Busy      = (mdCount != 4'd0);
    end

    // Next consecutive-stall count, saturating so a long stall never wraps
    always_comb begin
        wdogNext = 8'd0;
        if (stall) begin
            wdogNext = (wdogCount == 8'hFF) ? 8'hFF : wdogCount + 8'd1;
        end
    end

    // Mult/div occupancy timer; a new issue reloads even if the unit is busy
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            mdCount <= 4'd0;
        end else if (EX_MDStart) begin
            mdCount <= MdLoad;
        end else if (mdCount != 4'd0) begin
            mdCount <= mdCount - 4'd1;
        end
    end

    // Free-running stall-cycle performance counter
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            STALL_COUNT <= '0;
        end else if (stall) begin
            STALL_COUNT <= STALL_COUNT + 1'b1;
        end
    end

    // Stuck-pipeline watchdog with a sticky trip flag
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            wdogCount <= 8'd0;
            WDOG_TRIP <= 1'b0;
        end else begin
            wdogCount <= wdogNext;
            if (wdogNext == WdogLimit) begin
                WDOG_TRIP <= 1'b1;
            end
        end
    end

endmodule
